// File: rtl/asic_function_batch_interface.sv
// SPI DAC write, LDAC strobe, settle wait, ADC conversion and handshaked result, one request at a time.
// Define ASIC_FUNC_AVG_EN to average 2^AVG_LOG2 conversions per request (truncating mean).
module asic_function_batch_interface #(
  parameter int DATA_WIDTH    = 16,
  parameter int NUM_CHANNELS  = 4,
  parameter int SCLK_DIV      = 4,
  parameter int SETTLE_CYCLES = 100,
  parameter int AVG_LOG2      = 2,
  localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CH_W-1:0]       in_channel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CH_W-1:0]       out_channel,
  output logic                  adc_start,
  input  logic                  adc_valid,
  input  logic [DATA_WIDTH-1:0] adc_data,
  output logic                  dac_cs_n,
  output logic                  dac_ldac_n,
  output logic                  dac_din,
  output logic                  dac_sclk,
  output logic                  busy
);
  localparam int CNT_MAX = (SCLK_DIV > SETTLE_CYCLES) ? SCLK_DIV : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HALF_LAST   = CNT_W'(SCLK_DIV - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [4:0]       LAST_BIT    = 5'd23;

  typedef enum logic [2:0] {IDLE, SHIFT, LOAD, SETTLE, CONVERT, OUTPUT} state_t;

  state_t                state_q;
  logic                  in_ready_q;
  logic                  cs_n_q;
  logic                  ldac_n_q;
  logic                  sclk_q;
  logic                  din_q;
  logic                  adc_start_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [CH_W-1:0]       out_channel_q;
  logic [CH_W-1:0]       chan_q;
  logic [23:0]           shreg_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [4:0]            bit_q;

  logic [15:0]           code_d;
  logic [23:0]           frame_d;

  // Command nibble 0011, channel nibble, then the code left-justified into 16 bits.
  assign code_d  = 16'(in_data) << (16 - DATA_WIDTH);
  assign frame_d = {4'b0011, 4'(in_channel), code_d};

`ifdef ASIC_FUNC_AVG_EN
  localparam int ACC_W  = DATA_WIDTH + AVG_LOG2;
  localparam int CONV_W = AVG_LOG2 + 1;
  localparam logic [CONV_W-1:0] CONV_LAST = CONV_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  acc_d;
  logic [CONV_W-1:0] conv_q;

  function automatic logic [DATA_WIDTH-1:0] avg_trunc(input logic [ACC_W-1:0] sum);
    return sum[ACC_W-1:AVG_LOG2];
  endfunction

  assign acc_d = acc_q + ACC_W'(adc_data);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      in_ready_q    <= 1'b0;
      cs_n_q        <= 1'b1;
      ldac_n_q      <= 1'b1;
      sclk_q        <= 1'b0;
      din_q         <= 1'b0;
      adc_start_q   <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_channel_q <= '0;
      chan_q        <= '0;
      shreg_q       <= '0;
      cnt_q         <= '0;
      bit_q         <= '0;
`ifdef ASIC_FUNC_AVG_EN
      acc_q         <= '0;
      conv_q        <= '0;
`endif
    end else begin
      adc_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            in_ready_q <= 1'b0;
            chan_q     <= in_channel;
            din_q      <= frame_d[23];
            shreg_q    <= {frame_d[22:0], 1'b0};
            cs_n_q     <= 1'b0;
            sclk_q     <= 1'b0;
            cnt_q      <= '0;
            bit_q      <= '0;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          // dac_din changes only on the falling half so it is stable around each rising edge.
          if (cnt_q == HALF_LAST) begin
            cnt_q <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else begin
              sclk_q <= 1'b0;
              if (bit_q == LAST_BIT) begin
                cs_n_q   <= 1'b1;
                ldac_n_q <= 1'b0;
                din_q    <= 1'b0;
                state_q  <= LOAD;
              end else begin
                bit_q   <= bit_q + 5'd1;
                din_q   <= shreg_q[23];
                shreg_q <= {shreg_q[22:0], 1'b0};
              end
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        LOAD: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q    <= '0;
            ldac_n_q <= 1'b1;
            state_q  <= SETTLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_q       <= '0;
            adc_start_q <= 1'b1;
            state_q     <= CONVERT;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        CONVERT: begin
          if (adc_valid) begin
`ifdef ASIC_FUNC_AVG_EN
            if (conv_q == CONV_LAST) begin
              acc_q         <= '0;
              conv_q        <= '0;
              out_data_q    <= avg_trunc(acc_d);
              out_channel_q <= chan_q;
              out_valid_q   <= 1'b1;
              state_q       <= OUTPUT;
            end else begin
              acc_q       <= acc_d;
              conv_q      <= conv_q + CONV_W'(1);
              adc_start_q <= 1'b1;
            end
`else
            out_data_q    <= adc_data;
            out_channel_q <= chan_q;
            out_valid_q   <= 1'b1;
            state_q       <= OUTPUT;
`endif
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_channel = out_channel_q;
  assign adc_start   = adc_start_q;
  assign dac_cs_n    = cs_n_q;
  assign dac_ldac_n  = ldac_n_q;
  assign dac_din     = din_q;
  assign dac_sclk    = sclk_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_asic_function_batch_interface.sv
// Bench for asic_function_batch_interface: vector table, hand-written corner sequences and random requests.
module tb_asic_function_batch_interface;
  localparam int DW  = 16;
  localparam int NCH = 4;
  localparam int D   = 4;
  localparam int S   = 100;
  localparam int AL  = 2;
`ifdef ASIC_FUNC_AVG_EN
  localparam int NCONV = 1 << AL;
`else
  localparam int NCONV = 1;
`endif
  // Edges from the accept edge to out_valid: 48*D shift, D load, S settle, two clocks per conversion with a one-cycle ADC.
  localparam int EXP_LAT = 49*D + S + 2*NCONV;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [1:0]    in_channel = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [1:0]    out_channel;
  logic          adc_start;
  logic          adc_valid = 1'b0;
  logic [DW-1:0] adc_data = '0;
  logic          dac_cs_n, dac_ldac_n, dac_din, dac_sclk, busy;

  asic_function_batch_interface #(
    .DATA_WIDTH(DW), .NUM_CHANNELS(NCH), .SCLK_DIV(D), .SETTLE_CYCLES(S), .AVG_LOG2(AL)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_channel(in_channel),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_channel(out_channel),
    .adc_start(adc_start), .adc_valid(adc_valid), .adc_data(adc_data),
    .dac_cs_n(dac_cs_n), .dac_ldac_n(dac_ldac_n), .dac_din(dac_din), .dac_sclk(dac_sclk),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ADC model: answers one cycle after each adc_start with the next queued value.
  logic [DW-1:0] adc_q[$];
  logic [DW-1:0] adc_next = '0;
  bit            adc_pend = 1'b0;
  bit            spur_en  = 1'b0;
  always @(posedge clk) begin
    #1;
    adc_valid = 1'b0;
    if (adc_pend) begin
      adc_valid = 1'b1;
      adc_data  = adc_next;
      adc_pend  = 1'b0;
    end else if (spur_en) begin
      adc_valid = 1'b1;
      adc_data  = 16'hDEAD;
    end
    if (adc_start) begin
      adc_pend = 1'b1;
      if (adc_q.size() > 0) adc_next = adc_q.pop_front();
      else adc_next = DW'($urandom);
    end
  end

  // Bus monitor, sampled on the falling clock edge.
  int          rise_tot = 0, ldac_low_tot = 0, ldac_bad_tot = 0, start_tot = 0;
  int          rel_cyc = 0, st_cyc = 0;
  bit          want_st = 1'b0;
  logic [23:0] mon_frame = '0;
  logic        prev_cs = 1'b1, prev_sclk = 1'b0, prev_ldac = 1'b1;
  always @(negedge clk) begin
    if (prev_cs && !dac_cs_n) mon_frame = '0;
    if (dac_sclk && !prev_sclk) begin
      rise_tot++;
      if (!dac_cs_n) mon_frame = {mon_frame[22:0], dac_din};
    end
    if (!dac_ldac_n) begin
      ldac_low_tot++;
      if (!dac_cs_n) ldac_bad_tot++;
    end
    if (dac_ldac_n && !prev_ldac) begin
      rel_cyc = cyc;
      want_st = 1'b1;
    end
    if (adc_start) begin
      start_tot++;
      if (want_st) begin
        st_cyc  = cyc;
        want_st = 1'b0;
      end
    end
    prev_cs   = dac_cs_n;
    prev_sclk = dac_sclk;
    prev_ldac = dac_ldac_n;
  end

  task automatic do_txn(input logic [DW-1:0] data, input int ch, input int hold,
                        input logic [23:0] exp_frame, input logic [DW-1:0] exp_data,
                        input bit spur_settle, input string tag);
    int t, r0, l0, lb0, s0, acc_cyc, spur_left, bad;
    logic prev_l;
    logic [DW-1:0] d0;
    r0 = rise_tot; l0 = ldac_low_tot; lb0 = ldac_bad_tot; s0 = start_tot;
    t = 0;
    while (!in_ready && t < 1000) begin @(negedge clk); t++; end
    chk({tag, ".in_ready"}, in_ready, 1);
    in_data = data; in_channel = 2'(ch); in_valid = 1'b1;
    @(negedge clk);
    acc_cyc = cyc; in_valid = 1'b0;
    chk({tag, ".busy"}, busy, 1);
    chk({tag, ".ready_low"}, in_ready, 0);
    t = 0; spur_left = 0; prev_l = dac_ldac_n;
    while (!out_valid && t < 5000) begin
      if (spur_settle && dac_ldac_n && !prev_l) spur_left = 20;
      prev_l  = dac_ldac_n;
      spur_en = (spur_left > 0);
      if (spur_left > 0) spur_left--;
      @(negedge clk); t++;
    end
    spur_en = 1'b0;
    chk({tag, ".latency"}, cyc - acc_cyc, EXP_LAT);
    chk({tag, ".frame"}, mon_frame, exp_frame);
    chk({tag, ".sclk_rises"}, rise_tot - r0, 24);
    chk({tag, ".ldac_width"}, ldac_low_tot - l0, D);
    chk({tag, ".ldac_cs_overlap"}, ldac_bad_tot - lb0, 0);
    chk({tag, ".settle"}, st_cyc - rel_cyc, S);
    chk({tag, ".adc_starts"}, start_tot - s0, NCONV);
    chk({tag, ".out_data"}, out_data, exp_data);
    chk({tag, ".out_channel"}, out_channel, ch);
    d0 = out_data; bad = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!out_valid || out_data !== d0 || in_ready) bad++;
    end
    if (hold > 0) chk({tag, ".hold_stable"}, bad, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".out_valid_drop"}, out_valid, 0);
    chk({tag, ".ready_back"}, in_ready, 1);
    chk({tag, ".idle_bus"}, {dac_cs_n, dac_ldac_n, dac_sclk}, 3'b110);
  endtask

  typedef struct {
    logic [DW-1:0] data;
    int            ch;
    logic [DW-1:0] adc;
    int            hold;
    logic [23:0]   frame;
    logic [DW-1:0] exp;
  } vec_t;

  initial begin
    vec_t vt[4];
    int   r0, l0, s0, t, ov, ch, sum;
    logic [DW-1:0] dat, v;
    vt[0] = '{16'hA5C3, 2, 16'h1234, 0,  24'h32A5C3, 16'h1234};
    vt[1] = '{16'h0000, 0, 16'hFFFF, 3,  24'h300000, 16'hFFFF};
    vt[2] = '{16'hFFFF, 3, 16'h0000, 50, 24'h33FFFF, 16'h0000};
    vt[3] = '{16'h8001, 1, 16'h7FFE, 1,  24'h318001, 16'h7FFE};

    repeat (3) @(negedge clk);
    chk("rst.in_ready", in_ready, 0);
    chk("rst.cs_n", dac_cs_n, 1);
    chk("rst.ldac_n", dac_ldac_n, 1);
    chk("rst.sclk_din", {dac_sclk, dac_din}, 2'b00);
    chk("rst.adc_start", adc_start, 0);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.out_data", out_data, 0);
    chk("rst.out_channel", out_channel, 0);
    chk("rst.busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.ready_after_release", in_ready, 1);

    for (int i = 0; i < 4; i++) begin
      repeat (NCONV) adc_q.push_back(vt[i].adc);
      do_txn(vt[i].data, vt[i].ch, vt[i].hold, vt[i].frame, vt[i].exp, 1'b0, $sformatf("vec%0d", i));
    end

    // Stray adc_valid in IDLE, then again during SETTLE.
    spur_en = 1'b1;
    repeat (3) @(negedge clk);
    spur_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("spur.idle_no_output", out_valid, 0);
    repeat (NCONV) adc_q.push_back(16'h1111);
    do_txn(16'h0F0F, 3, 0, 24'h330F0F, 16'h1111, 1'b1, "spur");

    // Reset around the 10th SCLK of a frame aborts the request.
    r0 = rise_tot;
    in_data = 16'h5555; in_channel = 2'd1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    t = 0;
    while (rise_tot - r0 < 10 && t < 1000) begin @(negedge clk); t++; end
    chk("abort.reach_10th_sclk", rise_tot - r0 >= 10, 1);
    #2 rst = 1'b1;
    #1;
    chk("abort.cs_n", dac_cs_n, 1);
    chk("abort.ldac_n", dac_ldac_n, 1);
    chk("abort.sclk", dac_sclk, 0);
    chk("abort.busy_ready", {busy, in_ready}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort.ready_after_release", in_ready, 1);
    l0 = ldac_low_tot; s0 = start_tot; ov = 0;
    repeat (400) begin
      @(negedge clk);
      if (out_valid) ov++;
    end
    chk("abort.no_output", ov, 0);
    chk("abort.no_ldac", ldac_low_tot - l0, 0);
    chk("abort.no_adc_start", start_tot - s0, 0);
    repeat (NCONV) adc_q.push_back(16'h4321);
    do_txn(16'h00FF, 2, 2, 24'h3200FF, 16'h4321, 1'b0, "after_abort");

`ifdef ASIC_FUNC_AVG_EN
    adc_q.push_back(16'd100); adc_q.push_back(16'd101);
    adc_q.push_back(16'd102); adc_q.push_back(16'd104);
    do_txn(16'h0042, 1, 0, 24'h310042, 16'd101, 1'b0, "avg");
`endif

    for (int i = 0; i < 15; i++) begin
      dat = DW'($urandom);
      ch  = $urandom_range(NCH - 1, 0);
      sum = 0;
      for (int k = 0; k < NCONV; k++) begin
        v = DW'($urandom);
        adc_q.push_back(v);
        sum += int'(v);
      end
      do_txn(dat, ch, $urandom_range(5, 0), {4'b0011, 4'(ch), dat}, DW'(sum / NCONV), 1'b0,
             $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: got cycle %0d, expected end of test", cyc);
    $fatal(1, "timeout");
  end
endmodule
